// File: rtl/riscv_tag_policy_ctrl_pkg.sv
// Shared definitions for the DIFT tag-policy controller: register widths, CSR
// addresses and op codes, tag class/check bit positions and the sequencer states.
package riscv_tag_policy_ctrl_pkg;

  localparam int TPR_WIDTH = 14;
  localparam int TCR_WIDTH = 23;

  localparam logic [11:0] CSR_TPR_ADDR = 12'h700;
  localparam logic [11:0] CSR_TCR_ADDR = 12'h701;

  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam logic [1:0] ALU_MODE_OLD   = 2'b00;
  localparam logic [1:0] ALU_MODE_AND   = 2'b01;
  localparam logic [1:0] ALU_MODE_OR    = 2'b10;
  localparam logic [1:0] ALU_MODE_CLEAR = 2'b11;

  // Each TPR class owns a 2-bit propagation mode
  localparam int INTEGER_LOW   = 0;
  localparam int INTEGER_HIGH  = 1;
  localparam int LOADSTORE_LOW  = 12;
  localparam int LOADSTORE_HIGH = 13;

  localparam int INTEGER_CHECK_S1    = 0;
  localparam int EXECUTE_INSTRUCTION = 22;

  typedef enum logic [1:0] {
    TP_IDLE   = 2'd0,
    TP_DRAIN  = 2'd1,
    TP_COMMIT = 2'd2,
    TP_RESP   = 2'd3
  } tp_state_e;

  // Read-back value, zero-extended; bit 31 carries the lock flag on TCR reads
  function automatic logic [31:0] tp_read_value(
    input logic                 sel,
    input logic                 lock,
    input logic [TPR_WIDTH-1:0] tpr,
    input logic [TCR_WIDTH-1:0] tcr
  );
    logic [31:0] v;
    if (sel) v = {lock, {(31-TCR_WIDTH){1'b0}}, tcr};
    else     v = {{(32-TPR_WIDTH){1'b0}}, tpr};
    return v;
  endfunction

endpackage

// File: rtl/riscv_tag_policy_ctrl.sv
// Owns TPR/TCR and sequences CSR accesses: stall fetch, drain EX/WB, commit, respond.
// Optional sticky policy lock enabled by `define RISCV_TAG_POLICY_LOCK_EN.
//
// state     | meaning
// TP_IDLE   | waiting for a CSR request, latches operands
// TP_DRAIN  | fetch stalled, waiting for pipe_empty_i or timeout
// TP_COMMIT | fetch stalled, selected register updated
// TP_RESP   | one-cycle grant with pre-op read data and error flag
module riscv_tag_policy_ctrl
  import riscv_tag_policy_ctrl_pkg::*;
#(
  parameter logic [TPR_WIDTH-1:0] TPR_RST       = 14'h0000,
  parameter logic [TCR_WIDTH-1:0] TCR_RST       = 23'h000000,
  parameter int                   DRAIN_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 csr_req_i,
  input  logic                 csr_sel_i,
  input  logic [1:0]           csr_op_i,
  input  logic [31:0]          csr_wdata_i,
  output logic                 csr_gnt_o,
  output logic [31:0]          csr_rdata_o,
  output logic                 csr_err_o,
  input  logic                 pipe_empty_i,
  output logic                 stall_fetch_o,
  output logic [TPR_WIDTH-1:0] tpr_o,
  output logic [TCR_WIDTH-1:0] tcr_o
);

  localparam int              CNT_W    = $clog2(DRAIN_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  tp_state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_sel;
  logic [1:0]             r_op;
  logic [TCR_WIDTH-1:0]   r_wdata;
  logic [31:0]            r_rdata;
  logic                   r_err;
  logic [TPR_WIDTH-1:0]   r_tpr, w_tpr_nxt;
  logic [TCR_WIDTH-1:0]   r_tcr, w_tcr_nxt;
  logic                   w_unused_wdata;

`ifdef RISCV_TAG_POLICY_LOCK_EN
  logic r_lock;
  logic r_wd31;
`endif

  // Only bit 31 (lock build) and the TCR-wide low bits carry meaning
  assign w_unused_wdata = ^csr_wdata_i[31:TCR_WIDTH];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TP_IDLE: begin
        if (csr_req_i) begin
          if (csr_op_i == CSR_OP_NONE) w_state_nxt = TP_RESP;
`ifdef RISCV_TAG_POLICY_LOCK_EN
          else if (r_lock)             w_state_nxt = TP_RESP;
`endif
          else                         w_state_nxt = TP_DRAIN;
        end
      end
      TP_DRAIN: begin
        if (pipe_empty_i)           w_state_nxt = TP_COMMIT;
        else if (r_cnt == CNT_LAST) w_state_nxt = TP_RESP;
      end
      TP_COMMIT: w_state_nxt = TP_RESP;
      TP_RESP:   w_state_nxt = TP_IDLE;
      default:   w_state_nxt = TP_IDLE;
    endcase
  end

  always_comb begin
    w_tpr_nxt = r_tpr;
    w_tcr_nxt = r_tcr;
    case (r_op)
      CSR_OP_WRITE: begin
        w_tpr_nxt = r_wdata[TPR_WIDTH-1:0];
        w_tcr_nxt = r_wdata;
      end
      CSR_OP_SET: begin
        w_tpr_nxt = r_tpr | r_wdata[TPR_WIDTH-1:0];
        w_tcr_nxt = r_tcr | r_wdata;
      end
      CSR_OP_CLEAR: begin
        w_tpr_nxt = r_tpr & ~r_wdata[TPR_WIDTH-1:0];
        w_tcr_nxt = r_tcr & ~r_wdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TP_IDLE;
      r_cnt   <= '0;
      r_sel   <= 1'b0;
      r_op    <= CSR_OP_NONE;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_tpr   <= TPR_RST;
      r_tcr   <= TCR_RST;
`ifdef RISCV_TAG_POLICY_LOCK_EN
      r_lock  <= 1'b0;
      r_wd31  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        TP_IDLE: begin
          if (csr_req_i) begin
            r_sel   <= csr_sel_i;
            r_op    <= csr_op_i;
            r_wdata <= csr_wdata_i[TCR_WIDTH-1:0];
            r_cnt   <= '0;
`ifdef RISCV_TAG_POLICY_LOCK_EN
            r_wd31  <= csr_wdata_i[31];
            r_rdata <= tp_read_value(csr_sel_i, r_lock, r_tpr, r_tcr);
            r_err   <= r_lock && (csr_op_i != CSR_OP_NONE);
`else
            r_rdata <= tp_read_value(csr_sel_i, 1'b0, r_tpr, r_tcr);
            r_err   <= 1'b0;
`endif
          end
        end
        TP_DRAIN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (!pipe_empty_i && (r_cnt == CNT_LAST)) r_err <= 1'b1;
        end
        TP_COMMIT: begin
          if (r_sel) r_tcr <= w_tcr_nxt;
          else       r_tpr <= w_tpr_nxt;
`ifdef RISCV_TAG_POLICY_LOCK_EN
          if (r_sel && r_wd31 && ((r_op == CSR_OP_WRITE) || (r_op == CSR_OP_SET)))
            r_lock <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign csr_gnt_o     = (r_state == TP_RESP);
  assign csr_rdata_o   = csr_gnt_o ? r_rdata : 32'h0;
  assign csr_err_o     = csr_gnt_o & r_err;
  assign stall_fetch_o = (r_state == TP_DRAIN) || (r_state == TP_COMMIT);
  assign tpr_o         = r_tpr;
  assign tcr_o         = r_tcr;

endmodule

// File: tb/tb_riscv_tag_policy_ctrl.sv
// Self-checking bench for riscv_tag_policy_ctrl: directed plan items plus random
// CSR transactions scored against a transaction-level model of TPR/TCR.
module tb_riscv_tag_policy_ctrl;
  import riscv_tag_policy_ctrl_pkg::*;

  localparam int DT = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_req;
  logic        csr_sel;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        csr_gnt;
  logic [31:0] csr_rdata;
  logic        csr_err;
  logic        pipe_empty;
  logic        stall_fetch;
  logic [13:0] tpr;
  logic [22:0] tcr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [13:0] m_tpr;
  logic [22:0] m_tcr;
  logic        m_lock;

  riscv_tag_policy_ctrl #(
    .TPR_RST       (14'h0000),
    .TCR_RST       (23'h000000),
    .DRAIN_TIMEOUT (DT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .csr_req_i     (csr_req),
    .csr_sel_i     (csr_sel),
    .csr_op_i      (csr_op),
    .csr_wdata_i   (csr_wdata),
    .csr_gnt_o     (csr_gnt),
    .csr_rdata_o   (csr_rdata),
    .csr_err_o     (csr_err),
    .pipe_empty_i  (pipe_empty),
    .stall_fetch_o (stall_fetch),
    .tpr_o         (tpr),
    .tcr_o         (tcr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    csr_req    = 1'b0;
    pipe_empty = 1'b1;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    m_tpr  = 14'h0;
    m_tcr  = 23'h0;
    m_lock = 1'b0;
  endtask

  // d = index of the first drain cycle in which the pipe reports empty
  task automatic do_txn(input logic sel, input logic [1:0] op, input logic [31:0] wd,
                        input int d, input string tag);
    int          lat, stall_exp, stall_cnt, n;
    logic [31:0] exp_rd;
    logic        exp_err, got, commit;

    exp_rd = sel ? {m_lock, 8'h00, m_tcr} : {18'h0, m_tpr};
    commit = 1'b0;
    if (op == CSR_OP_NONE) begin
      lat = 1; exp_err = 1'b0; stall_exp = 0;
    end else if (m_lock) begin
      lat = 1; exp_err = 1'b1; stall_exp = 0;
    end else if (d < DT) begin
      lat = d + 3; exp_err = 1'b0; stall_exp = d + 2; commit = 1'b1;
    end else begin
      lat = DT + 1; exp_err = 1'b1; stall_exp = DT;
    end

    @(negedge clk);
    csr_req    = 1'b1;
    csr_sel    = sel;
    csr_op     = op;
    csr_wdata  = wd;
    pipe_empty = 1'b0;
    n = 0; got = 1'b0; stall_cnt = 0;

    if (commit) begin
      if (sel) begin
        case (op)
          CSR_OP_WRITE: m_tcr = wd[22:0];
          CSR_OP_SET:   m_tcr = m_tcr | wd[22:0];
          default:      m_tcr = m_tcr & ~wd[22:0];
        endcase
`ifdef RISCV_TAG_POLICY_LOCK_EN
        if (wd[31] && (op != CSR_OP_CLEAR)) m_lock = 1'b1;
`endif
      end else begin
        case (op)
          CSR_OP_WRITE: m_tpr = wd[13:0];
          CSR_OP_SET:   m_tpr = m_tpr | wd[13:0];
          default:      m_tpr = m_tpr & ~wd[13:0];
        endcase
      end
    end

    while (!got && n < DT + 10) begin
      @(negedge clk);
      n++;
      stall_cnt += int'(stall_fetch);
      pipe_empty = (n >= d + 1);
      if (csr_gnt) begin
        got = 1'b1;
        check_val({tag, "/lat"},   n,         lat);
        check_val({tag, "/rdata"}, csr_rdata, exp_rd);
        check_val({tag, "/err"},   csr_err,   exp_err);
        check_val({tag, "/tpr"},   tpr,       m_tpr);
        check_val({tag, "/tcr"},   tcr,       m_tcr);
        csr_req = 1'b0;
      end
    end
    check_val({tag, "/gnt_seen"}, got,       1);
    check_val({tag, "/stall"},    stall_cnt, stall_exp);
    pipe_empty = 1'b1;
    @(negedge clk);
    check_val({tag, "/gnt_pulse"}, csr_gnt,     0);
    check_val({tag, "/stall_off"}, stall_fetch, 0);
  endtask

  initial begin
    logic        r_sel;
    logic [1:0]  r_op;
    logic [31:0] r_wd;
    int          r_d;

    rst = 1'b1; csr_req = 1'b0; csr_sel = 1'b0; csr_op = CSR_OP_NONE;
    csr_wdata = 32'h0; pipe_empty = 1'b1;
    do_reset();

    check_val("rst/gnt",   csr_gnt,     0);
    check_val("rst/err",   csr_err,     0);
    check_val("rst/rdata", csr_rdata,   0);
    check_val("rst/stall", stall_fetch, 0);
    check_val("rst/tpr",   tpr,         0);
    check_val("rst/tcr",   tcr,         0);

    do_txn(1'b1, CSR_OP_NONE,  32'h0,         0, "t1_read_tcr");
    do_txn(1'b0, CSR_OP_WRITE, 32'hFFFF_2A55, 0, "t2_write_tpr");
    check_val("t2/tpr_val", tpr, 14'h2A55);
    do_txn(1'b1, CSR_OP_WRITE, 32'h0000_000F, 0, "t3_write_tcr");
    do_txn(1'b1, CSR_OP_SET,   32'h0000_0030, 0, "t3_set_tcr");
    check_val("t3/tcr_set", tcr, 23'h00003F);
    do_txn(1'b1, CSR_OP_CLEAR, 32'h0000_0003, 1, "t3_clr_tcr");
    check_val("t3/tcr_clr", tcr, 23'h00003C);
    do_txn(1'b0, CSR_OP_WRITE, 32'h0000_1111, 1000, "t4_timeout");
    do_txn(1'b0, CSR_OP_SET,   32'h0000_0100, 5,      "t5_late_empty");
    do_txn(1'b0, CSR_OP_CLEAR, 32'h0000_0004, DT - 1, "t5_tie");
    do_txn(1'b1, CSR_OP_SET,   32'h0000_0200, DT,     "t5_just_late");
    do_txn(1'b0, CSR_OP_WRITE, 32'h0000_2A55, 0,      "t5_same_data");

    // Reset in the middle of a drain
    @(negedge clk);
    csr_req = 1'b1; csr_sel = 1'b0; csr_op = CSR_OP_WRITE; csr_wdata = 32'h1234;
    pipe_empty = 1'b0;
    repeat (4) @(negedge clk);
    check_val("t6/stall_before", stall_fetch, 1);
    rst = 1'b1; csr_req = 1'b0;
    @(negedge clk);
    check_val("t6/stall_rel", stall_fetch, 0);
    check_val("t6/no_gnt",    csr_gnt,     0);
    check_val("t6/tpr_rst",   tpr,         0);
    check_val("t6/tcr_rst",   tcr,         0);
    rst = 1'b0; pipe_empty = 1'b1;
    m_tpr = 14'h0; m_tcr = 23'h0; m_lock = 1'b0;

    // Reset landing on the commit cycle must suppress the update
    @(negedge clk);
    csr_req = 1'b1; csr_sel = 1'b1; csr_op = CSR_OP_WRITE; csr_wdata = 32'h55;
    repeat (2) @(negedge clk);
    rst = 1'b1; csr_req = 1'b0;
    @(negedge clk);
    check_val("t6c/tcr_rst", tcr,         0);
    check_val("t6c/stall",   stall_fetch, 0);
    check_val("t6c/no_gnt",  csr_gnt,     0);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      r_sel = 1'($urandom_range(0, 1));
      r_op  = 2'($urandom_range(0, 3));
      r_wd  = $urandom;
      r_wd[31] = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0:       r_d = $urandom_range(0, 3);
        1:       r_d = $urandom_range(DT - 2, DT + 1);
        default: r_d = $urandom_range(0, 20);
      endcase
      do_txn(r_sel, r_op, r_wd, r_d, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    do_reset();
    do_txn(1'b1, CSR_OP_WRITE, 32'h8000_0001, 0, "t6_lock_tcr");
    do_txn(1'b0, CSR_OP_WRITE, 32'h0000_0001, 0, "t6_locked_tpr");
    do_txn(1'b1, CSR_OP_NONE,  32'h0,         0, "t6_read_tcr");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_tag_policy_ctrl.md
Name: riscv_tag_policy_ctrl

Overview:
Owns the DIFT tag-propagation register (TPR) and tag-check register (TCR) and sequences every CSR access to them. A policy change never affects an instruction already in flight: the controller stalls fetch, waits for the EX/WB pipeline to drain, then commits the change atomically. It sits beside the CS register file, and its outputs feed the ALU tag-propagation logic and the tag-check unit.

Parameters:
TPR_RST, 14'h0000, TPR reset value (7 classes x 2-bit mode; INTEGER at [1:0] up to LOADSTORE at [13:12])
TCR_RST, 23'h000000, TCR reset value (one enable per check bit, INTEGER_CHECK_S1=bit0 .. EXECUTE_INSTRUCTION=bit22)
DRAIN_TIMEOUT, 64, maximum DRAIN cycles before the request is aborted (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
csr_req_i  in  1  access request; held until csr_gnt_o
csr_sel_i  in  1  0=TPR, 1=TCR
csr_op_i  in  2  CSR_OP_NONE/WRITE/SET/CLEAR
csr_wdata_i  in  32  operand
csr_gnt_o  out  1  one-cycle completion pulse
csr_rdata_o  out  32  pre-op committed value, zero-extended; valid with gnt
csr_err_o  out  1  aborted (timeout/lock); valid with gnt
pipe_empty_i  in  1  no valid instruction in EX or WB
stall_fetch_o  out  1  hold the IF stage
tpr_o  out  14  committed TPR
tcr_o  out  23  committed TCR

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: tpr_o=TPR_RST, tcr_o=TCR_RST, csr_gnt_o=0, csr_err_o=0, csr_rdata_o=0, stall_fetch_o=0. State is IDLE and the timeout counter is 0.
- FSM states: IDLE, DRAIN, COMMIT, RESP.
- IDLE: when csr_req_i=1, latch sel, op and wdata. Go to RESP if op=NONE, otherwise to DRAIN. Requests are sampled only in IDLE.
- DRAIN: stall_fetch_o=1 and the counter increments every cycle.
  - If pipe_empty_i=1, go to COMMIT. This takes priority over timeout when both occur in the same cycle.
  - If counter==DRAIN_TIMEOUT-1 and the pipe is not empty, go to RESP with err set and no update.
- COMMIT: stall_fetch_o=1. Apply to the selected register:
  - WRITE: reg=wd
  - SET: reg|=wd
  - CLEAR: reg&=~wd
  - wd is truncated to 14 bits (TPR) or 23 bits (TCR); upper bits are ignored. Then go to RESP.
- RESP: csr_gnt_o=1 for exactly one cycle; csr_rdata_o = value before the op; csr_err_o as determined. Return to IDLE; stall_fetch_o=0.
- New values on tpr_o/tcr_o are visible from the cycle after COMMIT.
- Latency: read = 2 cycles (req to gnt). Write with pipe already empty = 4 cycles (IDLE, DRAIN, COMMIT, RESP).
- A req still high in the cycle after gnt is a new request.
- Dropping req mid-operation is a protocol violation; the block completes the operation anyway.
- Reset mid-DRAIN or mid-COMMIT: registers return to reset values, stall is released at once, and no gnt is issued.
- WRITE with identical data still drains (no bypass).

Optional Feature:
- Macro: RISCV_TAG_POLICY_LOCK_EN.
- Defined:
  - A sticky lock bit is set by a committed WRITE or SET to TCR with wdata[31]=1; it clears only on rst.
  - While locked, any WRITE/SET/CLEAR skips DRAIN and COMMIT: IDLE goes to RESP with err=1 and no update.
  - Reads are unaffected; csr_rdata_o[31] reflects the lock bit on TCR reads.
- Undefined: wdata[31] is ignored and no lock logic exists.

Decomposition:
- riscv_defines package gains:
  - TPR_WIDTH=14, TCR_WIDTH=23
  - CSR address constants for TPR and TCR
  - typedef enum for the FSM states
- It reuses the existing CSR_OP_*, ALU_MODE_*, *_CHECK_* and *_LOW/*_HIGH constants.
- No sub-module; the drain timeout counter is inline.

Test Plan:
1. Reset, then read TCR (op NONE) -> gnt 2 cycles after req, rdata=0, err=0, no stall.
2. pipe_empty_i=1, WRITE TPR 32'hFFFF_2A55 -> stall high 2 cycles, tpr_o=14'h2A55 the cycle after COMMIT, rdata=0.
3. TCR=23'h00000F, SET 32'h0000_0030 -> tcr_o=23'h00003F; then CLEAR 32'h3 -> 23'h00003C, rdata=23'h00003F.
4. pipe_empty_i held 0 -> after 64 DRAIN cycles gnt with err=1, TPR unchanged, stall released.
5. pipe_empty_i rises at DRAIN cycle 5 -> COMMIT next cycle, err=0. Also drive empty and timeout in the same cycle -> commit wins.
6. rst asserted during DRAIN -> next cycle stall=0, no gnt, registers reset. With LOCK_EN: WRITE TCR 32'h8000_0001, then WRITE TPR 32'h1 -> err=1, TPR unchanged.
